// File: rtl/cont_sinc_cresc_if.sv
// Control and status bundle of the synchronous modulo-N up-counter.
// master drives the controls; slave is the counter itself.
interface cont_sinc_cresc_if #(
  parameter int WIDTH = 5
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             clr_ovf;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] gray;
  logic             tc;
  logic             wrap;
  logic             ovf;

  modport master (
    output en, load, load_val, clr_ovf,
    input  count, gray, tc, wrap, ovf
  );

  modport slave (
    input  en, load, load_val, clr_ovf,
    output count, gray, tc, wrap, ovf
  );
endinterface

// File: rtl/cont_sinc_cresc.sv
// Synchronous modulo-MODULUS up-counter: load (saturating), enable, combinational tc,
// registered wrap pulse, sticky overflow and a Gray copy updated on the same edge as count.
module cont_sinc_cresc #(
  parameter int WIDTH   = 5,
  parameter int MODULUS = 32
) (
  input logic              clk,
  input logic              clear,
  cont_sinc_cresc_if.slave bus
);

  if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
    $error("cont_sinc_cresc: MODULUS must lie in 2..2**WIDTH");
  end

  localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] LP_ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_gray;
  logic             r_wrap;
  logic             r_ovf;
  logic [WIDTH-1:0] w_next;
  logic             w_at_max;
  logic             w_wrap_evt;

  assign w_at_max = (r_count == LP_MAX);

  // Priority load > en > hold; clear is handled asynchronously in the register.
  always_comb begin
    w_next     = r_count;
    w_wrap_evt = 1'b0;
    if (bus.load) begin
      w_next = (bus.load_val > LP_MAX) ? LP_MAX : bus.load_val;
    end else if (bus.en) begin
      if (w_at_max) begin
        w_next     = '0;
        w_wrap_evt = 1'b1;
      end else begin
        w_next = r_count + LP_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_count <= '0;
      r_gray  <= '0;
      r_wrap  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_count <= w_next;
      // Gray is derived from the next count so it never lags count.
      r_gray  <= w_next ^ (w_next >> 1);
      r_wrap  <= w_wrap_evt;
      if (w_wrap_evt) begin
        r_ovf <= 1'b1;
      end else if (bus.clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign bus.count = r_count;
  assign bus.gray  = r_gray;
  assign bus.tc    = w_at_max & bus.en;
  assign bus.wrap  = r_wrap;
  assign bus.ovf   = r_ovf;

endmodule

// File: tb/tb_cont_sinc_cresc.sv
// Bench: four counters (mod 32, mod 10, and a mod-10 pair cascaded through tc) checked
// every falling edge against an arithmetic model, plus hand-computed directed checks.
module tb_cont_sinc_cresc;

  logic clk = 1'b0;
  logic clear;
  always #5 clk = ~clk;

  // Index 0: mod 32, 1: mod 10, 2: cascade low, 3: cascade high
  logic [3:0]      d_en, d_load, d_clr;
  logic [3:0][4:0] d_lv;
  logic [3:0][4:0] a_count, a_gray;
  logic [3:0]      a_tc, a_wrap, a_ovf;

  cont_sinc_cresc_if #(.WIDTH(5)) if32 ();
  cont_sinc_cresc_if #(.WIDTH(5)) if10 ();
  cont_sinc_cresc_if #(.WIDTH(5)) iflo ();
  cont_sinc_cresc_if #(.WIDTH(5)) ifhi ();

  cont_sinc_cresc #(.WIDTH(5), .MODULUS(32)) u_m32 (.clk(clk), .clear(clear), .bus(if32));
  cont_sinc_cresc #(.WIDTH(5), .MODULUS(10)) u_m10 (.clk(clk), .clear(clear), .bus(if10));
  cont_sinc_cresc #(.WIDTH(5), .MODULUS(10)) u_lo  (.clk(clk), .clear(clear), .bus(iflo));
  cont_sinc_cresc #(.WIDTH(5), .MODULUS(10)) u_hi  (.clk(clk), .clear(clear), .bus(ifhi));

  assign if32.en = d_en[0]; assign if32.load = d_load[0]; assign if32.load_val = d_lv[0]; assign if32.clr_ovf = d_clr[0];
  assign if10.en = d_en[1]; assign if10.load = d_load[1]; assign if10.load_val = d_lv[1]; assign if10.clr_ovf = d_clr[1];
  assign iflo.en = d_en[2]; assign iflo.load = d_load[2]; assign iflo.load_val = d_lv[2]; assign iflo.clr_ovf = d_clr[2];
  assign ifhi.en = iflo.tc; assign ifhi.load = d_load[3]; assign ifhi.load_val = d_lv[3]; assign ifhi.clr_ovf = d_clr[3];

  assign a_count = {ifhi.count, iflo.count, if10.count, if32.count};
  assign a_gray  = {ifhi.gray,  iflo.gray,  if10.gray,  if32.gray};
  assign a_tc    = {ifhi.tc,    iflo.tc,    if10.tc,    if32.tc};
  assign a_wrap  = {ifhi.wrap,  iflo.wrap,  if10.wrap,  if32.wrap};
  assign a_ovf   = {ifhi.ovf,   iflo.ovf,   if10.ovf,   if32.ovf};

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int mod_k [4] = '{32, 10, 10, 10};
  int m_count [4];
  bit m_wrap [4];
  bit m_ovf  [4];

  function automatic bit m_en(input int k);
    if (k == 3) return d_en[2] && (m_count[2] == mod_k[2] - 1);
    return d_en[k];
  endfunction

  always @(posedge clk or posedge clear) begin
    bit e [4];
    if (clear) begin
      for (int k = 0; k < 4; k++) begin
        m_count[k] = 0; m_wrap[k] = 1'b0; m_ovf[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 4; k++) e[k] = m_en(k);
      for (int k = 0; k < 4; k++) begin
        bit wrapped;
        wrapped = 1'b0;
        if (d_load[k]) begin
          m_count[k] = (int'(d_lv[k]) > mod_k[k] - 1) ? mod_k[k] - 1 : int'(d_lv[k]);
        end else if (e[k]) begin
          wrapped    = (m_count[k] == mod_k[k] - 1);
          m_count[k] = (m_count[k] + 1) % mod_k[k];
        end
        m_wrap[k] = wrapped;
        if (wrapped) m_ovf[k] = 1'b1;
        else if (d_clr[k]) m_ovf[k] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("model_count[%0d]", k), int'(a_count[k]), m_count[k]);
        chk($sformatf("model_gray[%0d]", k), int'(a_gray[k]), m_count[k] ^ (m_count[k] >> 1));
        chk($sformatf("model_tc[%0d]", k), int'(a_tc[k]), int'(m_en(k) && m_count[k] == mod_k[k] - 1));
        chk($sformatf("model_wrap[%0d]", k), int'(a_wrap[k]), int'(m_wrap[k]));
        chk($sformatf("model_ovf[%0d]", k), int'(a_ovf[k]), int'(m_ovf[k]));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    clear = 1'b1;
    d_en = '0; d_load = '0; d_clr = '0; d_lv = '0;
    cyc(1);
    started = 1'b1;
    chk("reset_count", int'(a_count[0]), 0);
    chk("reset_tc", int'(a_tc[0]), 0);
    clear = 1'b0;

    // Free run through the 31 -> 0 wrap of the mod-32 counter
    d_en[0] = 1'b1;
    cyc(31);
    chk("m32_count31", int'(a_count[0]), 31);
    chk("m32_gray31", int'(a_gray[0]), 16);
    chk("m32_tc31", int'(a_tc[0]), 1);
    cyc(1);
    chk("m32_wrap_cnt", int'(a_count[0]), 0);
    chk("m32_wrap_pulse", int'(a_wrap[0]), 1);
    chk("m32_ovf_set", int'(a_ovf[0]), 1);
    cyc(3);
    chk("m32_count35", int'(a_count[0]), 3);
    chk("m32_wrap_gone", int'(a_wrap[0]), 0);
    chk("m32_ovf_sticky", int'(a_ovf[0]), 1);

    // clr_ovf coinciding with a wrap: set wins; next edge clears
    cyc(28);
    chk("m32_back_to31", int'(a_count[0]), 31);
    d_clr[0] = 1'b1;
    cyc(1);
    chk("ovf_set_wins", int'(a_ovf[0]), 1);
    cyc(1);
    chk("ovf_cleared", int'(a_ovf[0]), 0);
    chk("m32_count_after_clr", int'(a_count[0]), 1);
    d_clr[0] = 1'b0;
    d_en[0]  = 1'b0;

    // Mod-10 sequence, tc, and hold at 9
    d_en[1] = 1'b1;
    cyc(9);
    chk("m10_count9", int'(a_count[1]), 9);
    chk("m10_tc9", int'(a_tc[1]), 1);
    d_en[1] = 1'b0;
    #1;
    chk("m10_tc_en_low", int'(a_tc[1]), 0);
    cyc(2);
    chk("m10_hold9", int'(a_count[1]), 9);
    d_en[1] = 1'b1;
    cyc(1);
    chk("m10_wrap0", int'(a_count[1]), 0);
    chk("m10_wrap_pulse", int'(a_wrap[1]), 1);

    // Load beats enable, saturation, and a load at 9 must not set ovf
    d_load[1] = 1'b1; d_lv[1] = 5'd7;
    cyc(1);
    chk("load7_no_inc", int'(a_count[1]), 7);
    d_lv[1] = 5'd31; d_clr[1] = 1'b1;
    cyc(1);
    chk("load31_sat9", int'(a_count[1]), 9);
    chk("load_ovf_clr", int'(a_ovf[1]), 0);
    d_clr[1] = 1'b0; d_lv[1] = 5'd4;
    cyc(1);
    chk("load_at9", int'(a_count[1]), 4);
    chk("load_no_ovf", int'(a_ovf[1]), 0);
    chk("load_no_wrap", int'(a_wrap[1]), 0);
    d_load[1] = 1'b0; d_en[1] = 1'b0;

    // Asynchronous clear mid-cycle at count 13
    d_en[0] = 1'b1;
    cyc(12);
    chk("m32_count13", int'(a_count[0]), 13);
    #2;
    clear = 1'b1;
    #1;
    chk("async_count", int'(a_count[0]), 0);
    chk("async_gray", int'(a_gray[0]), 0);
    chk("async_wrap", int'(a_wrap[0]), 0);
    chk("async_ovf", int'(a_ovf[0]), 0);
    chk("async_m10_count", int'(a_count[1]), 0);
    cyc(1);
    clear = 1'b0;
    cyc(1);
    chk("resume_count1", int'(a_count[0]), 1);
    d_en[0] = 1'b0;

    // Cascaded decade pair
    d_en[2] = 1'b1;
    cyc(19);
    chk("casc19_hi", int'(a_count[3]), 1);
    chk("casc19_lo", int'(a_count[2]), 9);
    cyc(81);
    chk("casc100_hi", int'(a_count[3]), 0);
    chk("casc100_lo", int'(a_count[2]), 0);
    chk("casc100_hi_ovf", int'(a_ovf[3]), 1);
    cyc(19);
    chk("casc119_hi", int'(a_count[3]), 1);
    chk("casc119_lo", int'(a_count[2]), 9);
    cyc(1);
    d_en[2] = 1'b0;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
